wall_query_arbiter: RTL and testbench
=====================================

// Module: wall_query_arbiter
// PURPOSE
// - Time-multiplexes the single maze wall-check unit (walls) among NUM_ENT movers: Pac-Man (index 0) and ghosts (1..NUM_ENT-1).
// - Each mover posts (X, Y, direction); the block grants one requester round-robin and drives the checker from registered inputs.
// - It returns the checker's allowed bit with a one-cycle ack. Sits between the per-entity motion FSMs and the wall checker.
// PARAMETERS
// - NUM_ENT     5    number of requesters; index 0 is Pac-Man
// - MAZE_W_PX   224  maze width in pixels (28 tiles x 8)
// - MAZE_H_PX   248  maze height in pixels (31 tiles x 8)
// PORTS
// - Clk            in   1          system clock; all logic on posedge Clk
// - Reset          in   1          synchronous, active-high reset
// - req            in   NUM_ENT    per-entity query request; level, held until ack
// - ent_x          in   NUM_ENT*10 packed centre X per entity, entity i at [10i+9:10i]
// - ent_y          in   NUM_ENT*10 packed centre Y, same packing
// - ent_dir        in   NUM_ENT*2  packed direction: 00 up, 01 left, 10 down, 11 right
// - chk_entity     out  3          to checker: 1 = Pac-Man, 3 = ghost
// - chk_x, chk_y   out  10 each    to checker: registered query coordinates
// - chk_dir        out  2          to checker: registered query direction
// - chk_allowed    in   1          from checker: combinational result for chk_*
// - ack            out  NUM_ENT    one-hot, one-cycle pulse: result valid for that entity
// - result_allowed out  1          1 = move permitted; valid only while ack != 0
// - busy           out  1          high in LOOKUP and RESP
// BEHAVIOUR
// - Reset values: state IDLE; ack = 0; result_allowed = 0; busy = 0; chk_* = 0; rr pointer = 0.
// - Reset asserted mid-operation abandons the query: no ack is issued, and the block is in IDLE on the cycle after Reset falls.
// - FSM, 3 states:
//   - IDLE: if any req is high, the winner is the first set bit at or after the rr pointer, wrapping modulo NUM_ENT.
//     Latch winner index, ent_x, ent_y and ent_dir into the query registers. chk_entity = (idx == 0) ? 1 : 3.
//     Go to LOOKUP, or to RESP with forced deny if the query is out of range.
//   - LOOKUP: chk_* are stable from the registers. Sample chk_allowed into result_allowed at the end of the cycle. Go to RESP.
//   - RESP: ack[idx] = 1 (registered). Set rr pointer = idx + 1 mod NUM_ENT. Go to IDLE.
// - Latency: req seen in IDLE at cycle n -> ack at cycle n+2. Peak throughput is one query per 3 cycles.
// - Range guard, evaluated in IDLE on the latched values:
//   - In range only if 4 <= X <= MAZE_W_PX-4 and 4 <= Y <= MAZE_H_PX-4.
//   - Otherwise skip LOOKUP and go to RESP with result_allowed = 0. This prevents the checker's X-4 / X+3 tile index from under- or overflowing.
//   - Tunnel wrap is the motion FSM's job.
// - Handshake: the requester holds req and its operands stable until ack. Operands are sampled only once, in IDLE.
//   - If req[idx] falls during LOOKUP or RESP, the query still completes, but ack[idx] is suppressed and result_allowed is driven to 0.
//   - A requester that keeps req high on the cycle after its ack is treated as a new request and re-arbitrated normally.
//   - Because the rr pointer has moved past it, other pending requesters win first.
// - Simultaneous requests are handled by round-robin, so the wait is bounded at 3*NUM_ENT cycles.
// - req changing during LOOKUP or RESP has no effect until the next IDLE.
// - Arithmetic: range compares use 11-bit unsigned values to avoid wrap. The rr pointer is $clog2(NUM_ENT) bits, with explicit wrap at NUM_ENT-1.
// STRUCTURE
// - Shared package pacman_pkg:
//   - dir_t enum (UP = 2'b00, LEFT, DOWN, RIGHT)
//   - ENT_PACMAN = 3'd1, ENT_GHOST = 3'd3
//   - wq_state_t enum {IDLE, LOOKUP, RESP}
//   - TILE_PX = 8
// - Sub-module rr_arbiter (NUM_ENT requests, pointer in, one-hot grant and index out, purely combinational).
//   The FSM, query registers and range guard stay in this module.
// TESTING
// - Reset, then single req[0]: X=12, Y=12, dir=right, chk_allowed tied 1 -> chk_entity=1, chk_x=12; ack=00001 at cycle n+2, result_allowed=1.
// - req=11111 all held, chk_allowed=0 -> acks in order 0,1,2,3,4,0 at cycles n+2, n+5, ..., each with result_allowed=0, chk_entity 1,3,3,3,3.
// - Out-of-range: req[2] with X=2 -> no LOOKUP cycle; ack[2] at n+1... then RESP with result_allowed=0; chk_* unchanged.
// - Drop req[1] during LOOKUP -> ack stays 0, result_allowed=0, FSM back in IDLE, next requester served.
// - Reset pulsed during LOOKUP with req[3] high -> ack never pulses; after Reset, req[3] is re-granted from rr pointer 0 with ack at +2.
// - Back-to-back from one entity: req[0] held for 2 queries, req[4] raised mid-way -> order 0, 4, 0.

Source files
------------

// File: rtl/wall_query_arbiter_pkg.sv
// wall_query_arbiter_pkg: shared maze types, entity codes and the query range guard
package pacman_pkg;

    typedef enum logic [1:0] {UP = 2'b00, LEFT, DOWN, RIGHT} dir_t;
    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} wq_state_t;

    localparam logic [2:0] ENT_PACMAN = 3'd1;
    localparam logic [2:0] ENT_GHOST  = 3'd3;
    localparam int TILE_PX   = 8;
    localparam int HALF_TILE = TILE_PX / 2;

    // The checker looks at X-4 / X+3, so keep half a tile of margin on every edge
    function automatic logic in_range(input logic [9:0] x, input logic [9:0] y, input int w, input int h);
        logic [10:0] xe = {1'b0, x};
        logic [10:0] ye = {1'b0, y};
        return xe >= 11'(HALF_TILE) && xe <= 11'(w - HALF_TILE)
            && ye >= 11'(HALF_TILE) && ye <= 11'(h - HALF_TILE);
    endfunction

endpackage

// File: rtl/wall_query_arbiter_if.sv
// wall_query_arbiter_if: mover request bus plus wall-checker query bus
interface wall_query_arbiter_if
    import pacman_pkg::*;
#(
    parameter int NUM_ENT = 5
);
    logic [NUM_ENT-1:0]    req;
    logic [NUM_ENT*10-1:0] ent_x;
    logic [NUM_ENT*10-1:0] ent_y;
    logic [NUM_ENT*2-1:0]  ent_dir;
    logic [2:0]            chk_entity;
    logic [9:0]            chk_x;
    logic [9:0]            chk_y;
    dir_t                  chk_dir;
    logic                  chk_allowed;
    logic [NUM_ENT-1:0]    ack;
    logic                  result_allowed;
    logic                  busy;

    modport master (
        output req, ent_x, ent_y, ent_dir, chk_allowed,
        input  chk_entity, chk_x, chk_y, chk_dir, ack, result_allowed, busy
    );

    modport slave (
        input  req, ent_x, ent_y, ent_dir, chk_allowed,
        output chk_entity, chk_x, chk_y, chk_dir, ack, result_allowed, busy
    );
endinterface

// File: rtl/wall_query_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
    parameter  int N  = 5,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    function automatic logic [IW-1:0] slot(input logic [IW-1:0] p, input int k);
        int j = int'(p) + k;
        return IW'(j >= N ? j - N : j);
    endfunction

    // Scan farthest-first so the slot closest to ptr overwrites the others
    always_comb begin
        grant = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[slot(ptr, k)]) begin
                grant = '0;
                grant[slot(ptr, k)] = 1'b1;
                idx = slot(ptr, k);
            end
        end
    end

endmodule

// File: rtl/wall_query_arbiter.sv
// wall_query_arbiter: round-robin sharing of the single wall checker among the movers
module wall_query_arbiter
    import pacman_pkg::*;
#(
    parameter int NUM_ENT   = 5,
    parameter int MAZE_W_PX = 224,
    parameter int MAZE_H_PX = 248
) (
    input logic Clk,
    input logic Reset,
    wall_query_arbiter_if.slave bus
);

    localparam int IW = $clog2(NUM_ENT);

    wq_state_t          state;
    logic [NUM_ENT-1:0] grant;
    logic [IW-1:0]      win;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      ptr;
    logic [9:0]         xs [NUM_ENT];
    logic [9:0]         ys [NUM_ENT];
    dir_t               ds [NUM_ENT];

    for (genvar g = 0; g < NUM_ENT; g++) begin : g_unpack
        assign xs[g] = bus.ent_x[10*g +: 10];
        assign ys[g] = bus.ent_y[10*g +: 10];
        assign ds[g] = dir_t'(bus.ent_dir[2*g +: 2]);
    end

    rr_arbiter #(.N(NUM_ENT)) u_arb (
        .req  (bus.req),
        .ptr  (ptr),
        .grant(grant),
        .idx  (win)
    );

    // Grant in IDLE, sample the checker in LOOKUP, pulse ack and advance the pointer in RESP
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            idx <= '0;
            ptr <= '0;
            bus.ack <= '0;
            bus.result_allowed <= 1'b0;
            bus.busy <= 1'b0;
            bus.chk_entity <= '0;
            bus.chk_x <= '0;
            bus.chk_y <= '0;
            bus.chk_dir <= UP;
        end else begin
            case (state)
                IDLE: if (|grant) begin
                    idx <= win;
                    bus.busy <= 1'b1;
                    if (in_range(xs[win], ys[win], MAZE_W_PX, MAZE_H_PX)) begin
                        bus.chk_entity <= (win == '0) ? ENT_PACMAN : ENT_GHOST;
                        bus.chk_x <= xs[win];
                        bus.chk_y <= ys[win];
                        bus.chk_dir <= ds[win];
                        state <= LOOKUP;
                    end else begin
                        bus.ack <= grant;
                        bus.result_allowed <= 1'b0;
                        state <= RESP;
                    end
                end
                LOOKUP: begin
                    bus.ack <= bus.req[idx] ? NUM_ENT'(1) << idx : '0;
                    bus.result_allowed <= bus.req[idx] & bus.chk_allowed;
                    state <= RESP;
                end
                default: begin
                    bus.ack <= '0;
                    bus.result_allowed <= 1'b0;
                    bus.busy <= 1'b0;
                    ptr <= (idx == IW'(NUM_ENT - 1)) ? '0 : idx + 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wall_query_arbiter.sv
// tb_wall_query_arbiter: transaction-level model plus scoreboard for wall_query_arbiter
module tb_wall_query_arbiter;

    localparam int N = 5;
    localparam int W = 224;
    localparam int H = 248;

    typedef struct {
        int         at;
        logic [N-1:0] ack;
        logic       al;
        logic [2:0] ce;
        logic [9:0] cx;
        logic [9:0] cy;
        logic [1:0] cd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wall_query_arbiter_if #(.NUM_ENT(N)) bus();

    wall_query_arbiter #(.NUM_ENT(N), .MAZE_W_PX(W), .MAZE_H_PX(H)) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    int checks = 0;
    int passes = 0;
    int amode = 1;
    bit rnd = 0;
    bit mon_en = 0;
    logic [N-1:0] hold = '0;
    exp_t sb[$];
    int hist[$];

    function automatic logic wall_fn(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d);
        return x[3] ^ y[4] ^ d[0] ^ d[1];
    endfunction

    function automatic logic exp_allowed(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d);
        return amode == 1 ? 1'b1 : amode == 2 ? 1'b0 : wall_fn(x, y, d);
    endfunction

    assign bus.chk_allowed = amode == 1 ? 1'b1 : amode == 2 ? 1'b0 : wall_fn(bus.chk_x, bus.chk_y, bus.chk_dir);

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference model: one transaction at a time ----------------
    int cyc = 0;
    int m_ptr = 0, m_idle = 0, m_exit = -1, g_look = -1, g_idx = 0;
    bit m_busy = 0;
    logic [9:0] gx, gy, cx, cy;
    logic [1:0] gd, cd;
    logic [2:0] ce;

    initial forever begin
        int w, x, y;
        exp_t e;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_ptr = 0; m_idle = cyc + 1; m_busy = 0; g_look = -1; m_exit = -1;
            cx = '0; cy = '0; cd = '0; ce = '0;
        end else begin
            if (cyc == m_exit) m_busy = 0;
            if (cyc == g_look) begin
                e.at = cyc;
                e.ack = '0;
                if (bus.req[g_idx]) e.ack[g_idx] = 1'b1;
                e.al = bus.req[g_idx] && exp_allowed(gx, gy, gd);
                e.ce = ce; e.cx = cx; e.cy = cy; e.cd = cd;
                sb.push_back(e);
                g_look = -1;
            end
            if (cyc == m_idle) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                if (w < 0) m_idle = cyc + 1;
                else begin
                    x = int'(bus.ent_x[10*w +: 10]);
                    y = int'(bus.ent_y[10*w +: 10]);
                    m_busy = 1;
                    m_ptr = (w + 1) % N;
                    if (x >= 4 && x <= W - 4 && y >= 4 && y <= H - 4) begin
                        gx = 10'(x); gy = 10'(y); gd = bus.ent_dir[2*w +: 2];
                        ce = (w == 0) ? 3'd1 : 3'd3; cx = gx; cy = gy; cd = gd;
                        g_idx = w; g_look = cyc + 1; m_exit = cyc + 2; m_idle = cyc + 3;
                    end else begin
                        e.at = cyc; e.ack = '0; e.ack[w] = 1'b1; e.al = 1'b0;
                        e.ce = ce; e.cx = cx; e.cy = cy; e.cd = cd;
                        sb.push_back(e);
                        m_exit = cyc + 1; m_idle = cyc + 2;
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].at < cyc) begin
                e = sb.pop_front();
                checks++;
                $display("FAIL missed_ack: response due at edge %0d never checked, expected ack %b", e.at, e.ack);
            end
            if (sb.size() > 0 && sb[0].at == cyc) begin
                e = sb.pop_front();
                check("ack", int'(bus.ack), int'(e.ack));
                check("result_allowed", int'(bus.result_allowed), int'(e.al));
                check("chk_entity", int'(bus.chk_entity), int'(e.ce));
                check("chk_x", int'(bus.chk_x), int'(e.cx));
                check("chk_y", int'(bus.chk_y), int'(e.cy));
                check("chk_dir", int'(bus.chk_dir), int'(e.cd));
            end else if (bus.ack != '0) begin
                check("unexpected_ack", int'(bus.ack), 0);
            end
            check("busy", int'(bus.busy), int'(m_busy));
            for (int i = 0; i < N; i++) if (bus.ack[i]) hist.push_back(i);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_ops(input int i, input int x, input int y, input int d);
        bus.ent_x[10*i +: 10] = 10'(x);
        bus.ent_y[10*i +: 10] = 10'(y);
        bus.ent_dir[2*i +: 2] = 2'(d);
    endtask

    function automatic int rand_coord(input int max);
        int b;
        if ($urandom_range(0, 3) != 0) return int'($urandom_range(0, max));
        b = int'($urandom_range(0, 7));
        return b == 0 ? 0 : b == 1 ? 3 : b == 2 ? 4 : b == 3 ? 5 :
               b == 4 ? max - 5 : b == 5 ? max - 4 : b == 6 ? max - 3 : 1023;
    endfunction

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) if (bus.ack[i] && !hold[i]) bus.req[i] = 1'b0;
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                    set_ops(i, rand_coord(W), rand_coord(H), int'($urandom_range(0, 3)));
                    bus.req[i] = 1'b1;
                end else if (bus.req[i] && !bus.ack[i] && $urandom_range(0, 49) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
            rst = ($urandom_range(0, 299) == 0);
        end
    endtask

    task automatic do_reset();
        bus.req = '0;
        hold = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        hist.delete();
    endtask

    initial begin
        int exp2[6] = '{0, 1, 2, 3, 4, 0};
        int exp6[3] = '{0, 4, 0};
        bus.req = '0;
        bus.ent_x = '0;
        bus.ent_y = '0;
        bus.ent_dir = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1;
        @(negedge clk);
        check("rst_ack", int'(bus.ack), 0);
        check("rst_result_allowed", int'(bus.result_allowed), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_chk_x", int'(bus.chk_x), 0);
        check("rst_chk_y", int'(bus.chk_y), 0);
        check("rst_chk_dir", int'(bus.chk_dir), 0);
        check("rst_chk_entity", int'(bus.chk_entity), 0);

        // single Pac-Man query
        amode = 1;
        set_ops(0, 12, 12, 3);
        bus.req[0] = 1'b1;
        repeat (6) step();
        check("t1_count", hist.size(), 1);
        check("t1_who", hist.size() > 0 ? hist[0] : -1, 0);
        check("t1_chk_x", int'(bus.chk_x), 12);
        check("t1_chk_entity", int'(bus.chk_entity), 1);

        // all five held, checker denies
        do_reset();
        amode = 2;
        for (int i = 0; i < N; i++) set_ops(i, 20 + 10 * i, 30 + 10 * i, i % 4);
        hold = '1;
        bus.req = '1;
        repeat (19) step();
        hold = '0;
        bus.req = '0;
        repeat (5) step();
        for (int i = 0; i < 6; i++)
            check($sformatf("t2_order%0d", i), hist.size() > i ? hist[i] : -1, exp2[i]);

        // out-of-range query skips LOOKUP and leaves chk_* alone
        do_reset();
        amode = 1;
        set_ops(1, 50, 60, 1);
        bus.req[1] = 1'b1;
        repeat (5) step();
        set_ops(2, 2, 100, 2);
        bus.req[2] = 1'b1;
        repeat (4) step();
        check("t3_count", hist.size(), 2);
        check("t3_who", hist.size() > 1 ? hist[1] : -1, 2);
        check("t3_chk_x_kept", int'(bus.chk_x), 50);
        check("t3_chk_dir_kept", int'(bus.chk_dir), 1);

        // requester drops during LOOKUP
        do_reset();
        amode = 0;
        set_ops(1, 40, 40, 0);
        set_ops(3, 80, 90, 3);
        bus.req[1] = 1'b1;
        bus.req[3] = 1'b1;
        step();
        bus.req[1] = 1'b0;
        repeat (6) step();
        check("t4_count", hist.size(), 1);
        check("t4_who", hist.size() > 0 ? hist[0] : -1, 3);

        // reset during LOOKUP abandons the query
        do_reset();
        amode = 1;
        set_ops(3, 100, 100, 2);
        bus.req[3] = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        check("t5_count", hist.size(), 1);
        check("t5_who", hist.size() > 0 ? hist[0] : -1, 3);

        // back-to-back from Pac-Man with a ghost joining
        do_reset();
        amode = 0;
        set_ops(0, 12, 100, 1);
        set_ops(4, 200, 200, 3);
        hold[0] = 1'b1;
        bus.req[0] = 1'b1;
        step();
        bus.req[4] = 1'b1;
        repeat (12) step();
        hold = '0;
        bus.req = '0;
        repeat (5) step();
        for (int i = 0; i < 3; i++)
            check($sformatf("t6_order%0d", i), hist.size() > i ? hist[i] : -1, exp6[i]);

        // randomized traffic with drops and resets
        do_reset();
        amode = 0;
        rnd = 1;
        repeat (4000) step();
        rnd = 0;
        rst = 1'b0;
        bus.req = '0;
        repeat (6) step();
        check("rand_sb_drained", sb.size(), 0);
        check("rand_traffic", int'(hist.size() > 100), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
